// File: rtl/game_pkg.sv
// Shared game-flow types and constants: state encoding seen by the display side,
// HID keycodes shared with the motion modules, and output widths.
package game_pkg;

  typedef enum logic [3:0] {
    TITLE  = 4'd0,
    PLAY   = 4'd1,
    PAUSED = 4'd2,
    DEAD   = 4'd3,
    WIN    = 4'd4
  } game_state_t;

  localparam logic [7:0] KEY_START = 8'h28;
  localparam logic [7:0] KEY_PAUSE = 8'h29;
  localparam logic [7:0] KEY_RETRY = 8'h15;

  localparam int STATUS_W  = 4;
  localparam int DIAMOND_W = 4;
  localparam int SECONDS_W = 10;

  localparam logic [SECONDS_W-1:0] SECONDS_MAX = '1;

  // A key fires only on the cycle it first appears, so a held key acts once.
  function automatic logic keyEvent(input logic [7:0] cur, input logic [7:0] prev,
                                    input logic [7:0] key);
    return (cur == key) && (prev != key);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_tick_gen.sv
// Brings the VGA vertical-sync strobe into the system clock domain and turns each
// rising edge into a single-cycle frame_tick pulse.
module frame_tick_gen (
  input  logic clk_i,
  input  logic rst_i,
  input  logic frame_clk_i,
  output logic frame_tick_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic tick_q;

  // Two flops guard against metastability; the third remembers the last synced level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= sync2_q & ~prev_q;
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game-flow controller: title/play/pause/dead/win sequencing, timed end
// screens, and the per-attempt diamond and play-time counters.
module game_flow_ctrl #(
  parameter int         NUM_DIAMONDS = 1,
  parameter int         DEAD_FRAMES  = 120,
  parameter int         WIN_FRAMES   = 180,
  parameter int         FPS          = 60,
  parameter logic [7:0] KEY_START    = game_pkg::KEY_START,
  parameter logic [7:0] KEY_PAUSE    = game_pkg::KEY_PAUSE,
  parameter logic [7:0] KEY_RETRY    = game_pkg::KEY_RETRY
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           frame_clk_i,
  input  logic [7:0]                     keycode_i,
  input  logic                           is_dead_girl_i,
  input  logic                           is_diamond_eat_i,
  input  logic                           is_at_door_i,
  output logic [game_pkg::STATUS_W-1:0]  status_o,
  output logic                           freeze_o,
  output logic                           level_reset_o,
  output logic [game_pkg::DIAMOND_W-1:0] diamonds_o,
  output logic [game_pkg::SECONDS_W-1:0] play_seconds_o
);

  import game_pkg::*;

  localparam logic [DIAMOND_W-1:0] DIAM_FULL  = DIAMOND_W'(NUM_DIAMONDS);
  localparam logic [15:0]          DEAD_LAST  = 16'(DEAD_FRAMES - 1);
  localparam logic [15:0]          WIN_LAST   = 16'(WIN_FRAMES - 1);
  localparam logic [15:0]          PRESC_LAST = 16'(FPS - 1);

  game_state_t          state_q;
  logic                 freeze_q;
  logic                 levelReset_q;
  logic [15:0]          endTimer_q;
  logic [7:0]           keyPrev_q;
  logic                 eatPrev_q;
  logic [DIAMOND_W-1:0] diamonds_q, diamonds_d;
  logic [SECONDS_W-1:0] seconds_q, seconds_d;
  logic [15:0]          presc_q, presc_d;

  logic frameTick;
  logic evStart, evPause, evRetry;
  logic enterReset;
  logic countClear;

  frame_tick_gen uFrameTick (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .frame_clk_i  (frame_clk_i),
    .frame_tick_o (frameTick)
  );

  assign evStart = keyEvent(keycode_i, keyPrev_q, KEY_START);
  assign evPause = keyEvent(keycode_i, keyPrev_q, KEY_PAUSE);
  assign evRetry = keyEvent(keycode_i, keyPrev_q, KEY_RETRY);

  // Every fresh entry into PLAY; retry beats resume in PAUSED and the timeout in DEAD.
  assign enterReset = ((state_q == TITLE) && evStart) ||
                      (((state_q == PAUSED) || (state_q == DEAD)) && evRetry);

  assign countClear = enterReset || levelReset_q;

  always_comb begin
    diamonds_d = diamonds_q;
    seconds_d  = seconds_q;
    presc_d    = presc_q;
    if (countClear) begin
      diamonds_d = '0;
      seconds_d  = '0;
      presc_d    = '0;
    end else if (state_q == PLAY) begin
      if (is_diamond_eat_i && !eatPrev_q && (diamonds_q < DIAM_FULL)) begin
        diamonds_d = diamonds_q + 1'b1;
      end
      if (frameTick) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (seconds_q != SECONDS_MAX) begin
            seconds_d = seconds_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      keyPrev_q  <= 8'h00;
      eatPrev_q  <= 1'b0;
      diamonds_q <= '0;
      seconds_q  <= '0;
      presc_q    <= '0;
    end else begin
      keyPrev_q  <= keycode_i;
      eatPrev_q  <= is_diamond_eat_i;
      diamonds_q <= diamonds_d;
      seconds_q  <= seconds_d;
      presc_q    <= presc_d;
    end
  end

  // level_reset outlives the next frame tick so frame-clocked consumers always see it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= TITLE;
      freeze_q     <= 1'b1;
      levelReset_q <= 1'b0;
      endTimer_q   <= '0;
    end else begin
      if (enterReset) begin
        levelReset_q <= 1'b1;
      end else if (frameTick) begin
        levelReset_q <= 1'b0;
      end

      case (state_q)
        TITLE: begin
          if (evStart) begin
            state_q  <= PLAY;
            freeze_q <= 1'b0;
          end
        end
        PLAY: begin
          if (is_dead_girl_i) begin
            state_q    <= DEAD;
            freeze_q   <= 1'b1;
            endTimer_q <= '0;
          end else if (is_at_door_i && (diamonds_q == DIAM_FULL)) begin
            state_q    <= WIN;
            freeze_q   <= 1'b1;
            endTimer_q <= '0;
          end else if (evPause) begin
            state_q  <= PAUSED;
            freeze_q <= 1'b1;
          end
        end
        PAUSED: begin
          if (evRetry || evPause) begin
            state_q  <= PLAY;
            freeze_q <= 1'b0;
          end
        end
        DEAD: begin
          if (evRetry) begin
            state_q  <= PLAY;
            freeze_q <= 1'b0;
          end else if (frameTick) begin
            if (endTimer_q == DEAD_LAST) begin
              state_q <= TITLE;
            end else begin
              endTimer_q <= endTimer_q + 16'd1;
            end
          end
        end
        WIN: begin
          if (evStart) begin
            state_q <= TITLE;
          end else if (frameTick) begin
            if (endTimer_q == WIN_LAST) begin
              state_q <= TITLE;
            end else begin
              endTimer_q <= endTimer_q + 16'd1;
            end
          end
        end
        default: begin
          state_q  <= TITLE;
          freeze_q <= 1'b1;
        end
      endcase
    end
  end

  assign status_o       = state_q;
  assign freeze_o       = freeze_q;
  assign level_reset_o  = levelReset_q;
  assign diamonds_o     = diamonds_q;
  assign play_seconds_o = seconds_q;

endmodule
